// File: rtl/chip74161.sv
// chip74161: pin-faithful 74161 4-bit synchronous binary counter
module chip74161 (
  input  logic       CP,
  input  logic       N_MR,
  input  logic       N_PE,
  input  logic       CEP,
  input  logic       CET,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       TC
);
  logic [3:0] q_q, q_d;
  always_comb q_d = !N_PE ? D : (CEP && CET) ? q_q + 4'd1 : q_q;
  always_ff @(posedge CP or negedge N_MR)
    if (!N_MR) q_q <= 4'h0;
    else q_q <= q_d;
  assign Q  = q_q;
  assign TC = CET && (q_q == 4'hF);
`ifdef FORMAL
  logic f_valid_q;
  logic [3:0] f_exp_q;
  always_ff @(posedge CP or negedge N_MR)
    if (!N_MR) begin
      f_valid_q <= 1'b0;
      f_exp_q <= 4'h0;
    end else begin
      f_valid_q <= 1'b1;
      f_exp_q <= q_d;
    end
  always_comb begin
    if (!N_MR) assert (q_q == 4'h0 && !TC);
    assert (TC == (CET && q_q == 4'hF));
    if (N_MR && f_valid_q) assert (q_q == f_exp_q);
  end
`endif
endmodule

// File: tb/tb_chip74161.sv
module tb_chip74161;
   logic       CP = 1'b0, N_MR = 1'b1, N_PE = 1'b1, CEP = 1'b0, CET = 1'b0;
   logic [3:0] D = 4'h0, Q, Q1;
   logic       TC, TC1;
   int         n_chk = 0, n_fail = 0;
   int         m = 0;

   chip74161 u0 (.CP(CP), .N_MR(N_MR), .N_PE(N_PE), .CEP(CEP), .CET(CET), .D(D), .Q(Q), .TC(TC));
   chip74161 u1 (.CP(CP), .N_MR(N_MR), .N_PE(1'b1), .CEP(CEP), .CET(TC), .D(4'h0), .Q(Q1), .TC(TC1));

   always #5 CP = ~CP;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: one rising edge of the 74161 rules applied to the model count.
   task automatic tick();
      @(posedge CP);
      if (!N_MR)            m = 0;
      else if (!N_PE)       m = int'(D);
      else if (CEP && CET)  m = (m + 1) % 16;
      @(negedge CP);
      #1;
   endtask

   initial begin
      #1 N_MR = 1'b0;
      #1;
      chk("rst_q", Q, 0);
      chk("rst_tc", TC, 0);
      // reset held: loads and counts ignored
      N_PE = 1'b0; D = 4'hA; CEP = 1'b1; CET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_hold_q", Q, 0);
         chk("rst_hold_tc", TC, 0);
      end
      // release, load C, count through wrap
      N_MR = 1'b1; D = 4'hC;
      tick();
      chk("load_c", Q, 4'hC);
      N_PE = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("wrap_q", Q, (12 + i) % 16);
         chk("wrap_tc", TC, ((12 + i) % 16) == 15);
      end
      // hold at F with CET=1, then TC follows CET immediately
      N_PE = 1'b0; D = 4'hF;
      tick();
      N_PE = 1'b1; CEP = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_f_q", Q, 4'hF);
         chk("hold_f_tc", TC, 1);
      end
      CET = 1'b0;
      #1 chk("tc_cet_drop", TC, 0);
      // load beats count
      CEP = 1'b1; CET = 1'b1; N_PE = 1'b0; D = 4'h3;
      tick();
      chk("load_beats_cnt", Q, 4'h3);
      // async reset mid-count, release right behind the edge
      D = 4'h7;
      tick();
      N_PE = 1'b1;
      #2 N_MR = 1'b0; m = 0;
      #1 chk("async_rst", Q, 0);
      chk("async_rst_tc", TC, 0);
      @(posedge CP);
      #1 N_MR = 1'b1;
      chk("rst_edge_q", Q, 0);
      @(negedge CP);
      tick();
      chk("post_rst_cnt", Q, 1);
      // two-stage cascade over a full 8-bit cycle
      N_MR = 1'b0;
      #1 N_MR = 1'b1; m = 0;
      CEP = 1'b1; CET = 1'b1; N_PE = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         tick();
         chk("cascade_q", {Q1, Q}, k % 256);
         chk("cascade_tc", TC1, (k % 256) == 255);
      end
      // randomized traffic against the model
      N_MR = 1'b0;
      #1 N_MR = 1'b1; m = 0;
      for (int i = 0; i < 400; i++) begin
         N_PE = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
         CEP  = ($urandom_range(0, 3) != 0);
         CET  = ($urandom_range(0, 3) != 0);
         D    = 4'($urandom);
         if ($urandom_range(0, 31) == 0) begin
            N_MR = 1'b0; m = 0;
            #1 chk("rnd_async_q", Q, 0);
            N_MR = 1'b1;
         end
         #1 chk("rnd_tc_pre", TC, CET && m == 15);
         tick();
         chk("rnd_q", Q, m);
         chk("rnd_tc", TC, CET && m == 15);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
